register_file_mp: RTL and testbench

//  Parametrised multi-read-port register file for the RiSC-16 ASIC datapath and its wider derivatives.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_clear_seq.sv | 72 +++++++
 rtl/register_file_mp.sv | 95 +++++++++
 tb/tb_register_file_mp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions.
// Holds the clear-sequencer state encoding and the default data/address
// widths that decode and writeback also use.
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned RF_ADDR_W = 3;

endpackage : rf_pkg

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer for the register file.
// Steps through the bank one entry per cycle after a clear request and
// provides the write strobe and address used to zero each entry.
// Ports:
//   clk0     clock, rising edge
//   rstb0    asynchronous active-low reset
//   clr_req  start request, sampled in RF_IDLE only
//   busy     high while the sweep is running
//   clr_we   sweep write strobe (write zero to clr_addr)
//   clr_addr entry being cleared this cycle
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk0,
    input  logic              rstb0,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // Entry 0 is hardwired when ZERO_REG is set, so the sweep skips it.
    localparam logic [ADDR_W-1:0] START_ADDR = ZERO_REG ? ADDR_W'(1) : '0;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = START_ADDR;
                end
            end
            RF_CLEAR: begin
                clr_we = 1'b1;
                // Terminal count on the last entry; the counter never wraps.
                if (cnt_q == '1) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_addr = cnt_q;

endmodule : rf_clear_seq

// File: rtl/register_file_mp.sv
// Multi-read-port register file.
// One write port, NUM_RD registered read ports, optional hardwired-zero
// entry 0, optional write-to-read bypass and a bulk-clear sequencer.
// Ports:
//   clk0      clock, rising edge
//   rstb0     asynchronous active-low reset
//   csb0      active-low chip select; high blocks reads and writes
//   werf      active-low write enable
//   tgt_addr  write address
//   tgt_data  write data
//   rd_addr   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   packed registered read data, port k at [k*DATA_W +: DATA_W]
//   clr_req   bulk-clear start pulse
//   busy      high while the bulk clear runs
module register_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W    = RF_DATA_W,
    parameter int unsigned ADDR_W    = RF_ADDR_W,
    parameter int unsigned NUM_RD    = 2,
    parameter bit          ZERO_REG  = 1'b1,
    parameter bit          WR_BYPASS = 1'b1
) (
    input  logic                     clk0,
    input  logic                     rstb0,
    input  logic                     csb0,
    input  logic                     werf,
    input  logic [ADDR_W-1:0]        tgt_addr,
    input  logic [DATA_W-1:0]        tgt_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        bank_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                     seq_busy;
    logic                     clr_we;
    logic [ADDR_W-1:0]        clr_addr;
    logic                     ext_we;

    rf_clear_seq #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_clear_seq (
        .clk0     (clk0),
        .rstb0    (rstb0),
        .clr_req  (clr_req),
        .busy     (seq_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Qualified external write. Writes to a hardwired entry 0 are dropped
    // here so neither the bank nor the bypass path ever sees them.
    assign ext_we = !csb0 && !werf && !seq_busy &&
                    !(ZERO_REG && (tgt_addr == '0));

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (clr_we) begin
            bank_q[clr_addr] <= '0;
        end else if (ext_we) begin
            bank_q[tgt_addr] <= tgt_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data_d[k*DATA_W +: DATA_W] =
            (ZERO_REG && (ra == '0))                ? '0       :
            (WR_BYPASS && ext_we && (ra == tgt_addr)) ? tgt_data :
                                                      bank_q[ra];
    end

    // Deselected cycles hold the previous read data on every port.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            rd_data_q <= '0;
        end else if (!csb0) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = seq_busy;

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: two register files (hardwired zero + bypass, and plain
// entry 0 without bypass) share the same stimulus; a reference model
// predicts each cycle's outputs and a monitor compares after every edge.
module tb_register_file_mp;

    logic        clk0 = 1'b0;
    logic        rstb0 = 1'b1;
    logic        csb0 = 1'b1;
    logic        werf = 1'b1;
    logic [2:0]  tgt_addr = '0;
    logic [15:0] tgt_data = '0;
    logic [5:0]  rd_addr = '0;
    logic        clr_req = 1'b0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b;

    always #5 clk0 = ~clk0;

    register_file_mp #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b1), .WR_BYPASS(1'b1)
    ) dut_a (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .werf(werf),
        .tgt_addr(tgt_addr), .tgt_data(tgt_data), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .clr_req(clr_req), .busy(busy_a)
    );

    register_file_mp #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b0), .WR_BYPASS(1'b0)
    ) dut_b (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .werf(werf),
        .tgt_addr(tgt_addr), .tgt_data(tgt_data), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .clr_req(clr_req), .busy(busy_b)
    );

    typedef struct packed {
        logic [31:0] rd_a;
        logic        busy_a;
        logic [31:0] rd_b;
        logic        busy_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: index 0 = dut_a config, index 1 = dut_b config.
    logic [15:0] mem [2][8];
    logic [15:0] rde [2][2];
    bit          bsy [2];
    int          swp [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) mem[c][i] = '0;
            rde[c][0] = '0;
            rde[c][1] = '0;
            bsy[c] = 1'b0;
            swp[c] = 0;
        end
    endtask

    task automatic model_step(input int c, input bit csb, input bit we_n, input int ta,
                              input logic [15:0] td, input int a0, input int a1, input bit clr);
        bit zero, byp, qw;
        int a;
        zero = (c == 0);
        byp  = (c == 0);
        qw   = !csb && !we_n && !bsy[c] && !(zero && ta == 0);
        if (!csb) begin
            for (int k = 0; k < 2; k++) begin
                a = (k == 0) ? a0 : a1;
                if (zero && a == 0)            rde[c][k] = 16'h0000;
                else if (byp && qw && a == ta) rde[c][k] = td;
                else                           rde[c][k] = mem[c][a];
            end
        end
        if (bsy[c]) begin
            mem[c][swp[c]] = 16'h0000;
            swp[c]++;
            if (swp[c] == 8) bsy[c] = 1'b0;
        end else begin
            if (qw) mem[c][ta] = td;
            if (clr) begin
                bsy[c] = 1'b1;
                swp[c] = zero ? 1 : 0;
            end
        end
    endtask

    task automatic cyc(input bit csb, input bit we_n, input int ta, input logic [15:0] td,
                       input int a0, input int a1, input bit clr);
        exp_t e;
        @(negedge clk0);
        csb0     = csb;
        werf     = we_n;
        tgt_addr = 3'(ta);
        tgt_data = td;
        rd_addr  = {3'(a1), 3'(a0)};
        clr_req  = clr;
        model_step(0, csb, we_n, ta, td, a0, a1, clr);
        model_step(1, csb, we_n, ta, td, a0, a1, clr);
        e.rd_a   = {rde[0][1], rde[0][0]};
        e.busy_a = bsy[0];
        e.rd_b   = {rde[1][1], rde[1][0]};
        e.busy_b = bsy[1];
        exp_q.push_back(e);
    endtask

    task automatic wr(input int ta, input logic [15:0] td, input int a0, input int a1);
        cyc(1'b0, 1'b0, ta, td, a0, a1, 1'b0);
    endtask

    task automatic rd(input int a0, input int a1);
        cyc(1'b0, 1'b1, 0, 16'h0000, a0, a1, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_a"}, rd_data_a, 32'h0);
        chk({tag, "_busy_a"}, {31'h0, busy_a}, 32'h0);
        chk({tag, "_rd_b"}, rd_data_b, 32'h0);
        chk({tag, "_busy_b"}, {31'h0, busy_b}, 32'h0);
    endtask

    // Monitor: every edge produces one registered output set.
    always @(posedge clk0) begin
        exp_t e;
        #1;
        if (rstb0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("a_port0", {16'h0, rd_data_a[15:0]},  {16'h0, e.rd_a[15:0]});
            chk("a_port1", {16'h0, rd_data_a[31:16]}, {16'h0, e.rd_a[31:16]});
            chk("a_busy",  {31'h0, busy_a}, {31'h0, e.busy_a});
            chk("b_port0", {16'h0, rd_data_b[15:0]},  {16'h0, e.rd_b[15:0]});
            chk("b_port1", {16'h0, rd_data_b[31:16]}, {16'h0, e.rd_b[31:16]});
            chk("b_busy",  {31'h0, busy_b}, {31'h0, e.busy_b});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rstb0 = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk0);
        rstb0 = 1'b1;

        // Write then read back one cycle later.
        wr(3, 16'hBEEF, 0, 0);
        rd(3, 0);
        rd(0, 0);
        // Same-cycle write with both ports reading it.
        wr(5, 16'h1111, 0, 0);
        wr(5, 16'h1234, 5, 5);
        rd(5, 5);
        // Entry 0 write/read.
        wr(0, 16'hFFFF, 0, 0);
        rd(0, 0);
        // Fill, sweep, blocked write and ignored second request.
        for (int i = 0; i < 8; i++) wr(i, 16'(16'h1000 + i * 16'h0101), i, 7 - i);
        cyc(1'b0, 1'b1, 0, 16'h0000, 1, 2, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i == 2)      cyc(1'b0, 1'b0, 4, 16'h5555, 4, 7, 1'b0);
            else if (i == 4) cyc(1'b0, 1'b1, 0, 16'h0000, 6, 7, 1'b1);
            else             rd(i % 8, 7);
        end
        for (int i = 0; i < 8; i++) rd(i, 7 - i);
        // Deselected write attempt, reads hold.
        wr(2, 16'h7777, 0, 0);
        rd(2, 3);
        cyc(1'b1, 1'b0, 2, 16'hAAAA, 5, 6, 1'b0);
        rd(2, 2);
        // Asynchronous reset in the middle of a sweep.
        for (int i = 1; i < 8; i++) wr(i, 16'(16'hC000 + i), 0, 0);
        cyc(1'b0, 1'b1, 0, 16'h0000, 3, 4, 1'b1);
        rd(5, 6);
        rd(7, 1);
        @(negedge clk0);
        #2 rstb0 = 1'b0;
        #1 chk_reset_outputs("midclr");
        model_reset();
        @(negedge clk0);
        rstb0 = 1'b1;
        for (int i = 0; i < 8; i++) rd(i, 7 - i);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0),
                int'($urandom_range(0, 7)), 16'($urandom),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 39) == 0));
        end

        repeat (3) @(negedge clk0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_register_file_mp
